// File: rtl/mem_stream_loader_pkg.sv
// Shared opcodes, FSM state encoding and default geometry for the SNN weight/delay
// memory stream loader.
package mem_stream_loader_pkg;

  localparam int M_DEF  = 320;
  localparam int N_DEF  = 8;
  localparam int AW_DEF = 9;

  localparam logic [7:0] OPC_WRITE = 8'h01;
  localparam logic [7:0] OPC_READ  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_AHI     = 3'd2,
    ST_ALO     = 3'd3,
    ST_WRITE   = 3'd4,
    ST_READ    = 3'd5,
    ST_DISCARD = 3'd6
  } state_t;

endpackage

// File: rtl/mem_stream_loader_if.sv
// Byte-stream input, memory port and read-back/status bundle of the stream loader.
// The slave modport is the loader; the master modport is the deframer/memory side.
interface mem_stream_loader_if import mem_stream_loader_pkg::*; #(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
);

  logic          frame_start;
  logic          frame_end;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_we;
  logic [N-1:0]  mem_rdata;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          busy;
  logic          err;

  modport slave (
    input  frame_start, frame_end, in_valid, in_data, mem_rdata,
    output in_ready, mem_addr, mem_wdata, mem_we, rd_valid, rd_data, busy, err
  );

  modport master (
    output frame_start, frame_end, in_valid, in_data, mem_rdata,
    input  in_ready, mem_addr, mem_wdata, mem_we, rd_valid, rd_data, busy, err
  );

endinterface

// File: rtl/mem_stream_loader_addr_ptr.sv
// Loadable AW-bit memory pointer that wraps from M-1 to 0.
// o_ptr_nxt/o_out_of_range describe the value the pointer takes on the next edge.
module mem_addr_ptr import mem_stream_loader_pkg::*; #(
  parameter int M  = M_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load_hi,
  input  logic          i_load_lo,
  input  logic          i_inc,
  input  logic [7:0]    i_byte,
  output logic [AW-1:0] o_ptr,
  output logic [AW-1:0] o_ptr_nxt,
  output logic          o_out_of_range
);

  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_load_hi) begin
      w_ptr_nxt[AW-1:8] = i_byte[AW-9:0];
    end else if (i_load_lo) begin
      w_ptr_nxt[7:0] = i_byte;
    end else if (i_inc) begin
      // >= rather than == so a stray out-of-range value still recovers to 0
      if (r_ptr >= AW'(M - 1)) begin
        w_ptr_nxt = '0;
      end else begin
        w_ptr_nxt = r_ptr + AW'(1);
      end
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_ptr          = r_ptr;
  assign o_ptr_nxt      = w_ptr_nxt;
  assign o_out_of_range = ({1'b0, w_ptr_nxt} >= (AW + 1)'(M));

endmodule

// File: rtl/mem_stream_loader.sv
// Command parser for the SNN register-file memory: CMD, ADDR_HI, ADDR_LO, then a
// burst of data bytes written to, or read back from, consecutive wrapping addresses.
module mem_stream_loader import mem_stream_loader_pkg::*; #(
  parameter int M  = M_DEF,
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  mem_stream_loader_if.slave bus
);

  state_t        r_state;
  logic          r_busy;
  logic          r_mode_rd;
  logic          r_err;
  logic          r_mem_we;
  logic          r_rd_valid;
  logic [AW-1:0] r_mem_addr;
  logic [N-1:0]  r_mem_wdata;
  logic [7:0]    r_rd_data;

  logic          w_acc;
  logic          w_load_hi;
  logic          w_load_lo;
  logic          w_inc;
  logic          w_nxt_oor;
  logic [AW-1:0] w_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic [7:0]    w_rd_byte;

  // frame_start aborts the frame, so a byte arriving with it is dropped
  assign w_acc     = bus.in_valid & r_busy & ~bus.frame_start;
  assign w_load_hi = w_acc & (r_state == ST_AHI);
  assign w_load_lo = w_acc & (r_state == ST_ALO);
  assign w_inc     = w_acc & ((r_state == ST_WRITE) | (r_state == ST_READ));

  mem_addr_ptr #(.M(M), .AW(AW)) u_ptr (
    .clk            (clk),
    .reset          (reset),
    .i_load_hi      (w_load_hi),
    .i_load_lo      (w_load_lo),
    .i_inc          (w_inc),
    .i_byte         (bus.in_data),
    .o_ptr          (w_ptr),
    .o_ptr_nxt      (w_ptr_nxt),
    .o_out_of_range (w_nxt_oor)
  );

  always_comb begin
    w_rd_byte        = 8'h00;
    w_rd_byte[N-1:0] = bus.mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_mode_rd   <= 1'b0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= 8'h00;
    end else begin
      r_mem_we   <= 1'b0;
      r_rd_valid <= 1'b0;
      // a write address lags the pointer by one cycle; catch up after each write
      if (r_mem_we) begin
        r_mem_addr <= w_ptr;
      end
      if (bus.frame_start) begin
        r_state <= ST_CMD;
        r_busy  <= 1'b1;
        r_err   <= 1'b0;
      end else begin
        if (w_acc) begin
          case (r_state)
            ST_CMD: begin
              if (bus.in_data == OPC_WRITE) begin
                r_mode_rd <= 1'b0;
                r_state   <= ST_AHI;
              end else if (bus.in_data == OPC_READ) begin
                r_mode_rd <= 1'b1;
                r_state   <= ST_AHI;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_DISCARD;
              end
            end
            ST_AHI: r_state <= ST_ALO;
            ST_ALO: begin
              if (w_nxt_oor) begin
                r_err   <= 1'b1;
                r_state <= ST_DISCARD;
              end else begin
                r_state    <= r_mode_rd ? ST_READ : ST_WRITE;
                r_mem_addr <= w_ptr_nxt;
              end
            end
            ST_WRITE: begin
              r_mem_we    <= 1'b1;
              r_mem_wdata <= bus.in_data[N-1:0];
              r_mem_addr  <= w_ptr;
            end
            ST_READ: begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= w_rd_byte;
              r_mem_addr <= w_ptr_nxt;
            end
            ST_DISCARD: r_state <= ST_DISCARD;
            default: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
        if (bus.frame_end) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = r_busy;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Scoreboard bench for mem_stream_loader: a frame-level reference model queues the
// expected writes and read-back bytes; a negedge monitor pops and compares them.
module tb_mem_stream_loader;

  localparam int M  = 320;
  localparam int N  = 8;
  localparam int AW = 9;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic reset;
  logic clr_mem;

  int total;
  int bad;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] ref_mem[0:M-1];
  logic [7:0] dut_mem[0:(1<<AW)-1];
  logic [7:0] fq[$];

  mem_stream_loader_if #(.N(N), .AW(AW)) bus ();

  mem_stream_loader #(.M(M), .N(N), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory attached to the DUT: combinational read, write on the clock edge
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < (1 << AW); i++) dut_mem[i] <= 8'h00;
    end else if (bus.mem_we) begin
      dut_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = dut_mem[bus.mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_mem_we", 32'(bus.mem_we), 32'd0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.mem_wdata), 32'(e.data));
        end
      end
      if (bus.rd_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rd_valid", 32'(bus.rd_valid), 32'd0);
        end else begin
          logic [7:0] d;
          d = rq.pop_front();
          chk("rd_data", 32'(bus.rd_data), 32'(d));
        end
      end
    end
  end

  // frame-level model: decode the whole byte list at once
  task automatic model_frame(input logic [7:0] b[$], output bit e);
    int a;
    bit wr;
    e = 1'b0;
    if (b.size() == 0) return;
    if (b[0] == 8'h01) wr = 1'b1;
    else if (b[0] == 8'h02) wr = 1'b0;
    else begin
      e = 1'b1;
      return;
    end
    if (b.size() < 3) return;
    a = int'({b[1][0], b[2]});
    if (a >= M) begin
      e = 1'b1;
      return;
    end
    for (int i = 3; i < b.size(); i++) begin
      if (wr) begin
        wq.push_back('{a, b[i]});
        ref_mem[a] = b[i];
      end else begin
        rq.push_back(ref_mem[a]);
      end
      a = (a + 1) % M;
    end
  endtask

  task automatic send_frame(input logic [7:0] b[$], input int gap_max,
                            input bit end_last, input bit do_end);
    bit e;
    model_frame(b, e);
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    chk("err_cleared", 32'(bus.err), 32'd0);
    chk("busy_on", 32'(bus.busy), 32'd1);
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b[i];
      bus.frame_end = (end_last && (i == b.size() - 1));
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.frame_end = 1'b0;
    end
    if (do_end) begin
      if (!end_last || b.size() == 0) begin
        bus.frame_end = 1'b1;
        @(posedge clk); #1;
        bus.frame_end = 1'b0;
      end
      repeat (2) begin
        @(posedge clk); #1;
      end
      chk("err_end", 32'(bus.err), 32'(e));
      chk("busy_off", 32'(bus.busy), 32'd0);
      chk("in_ready_off", 32'(bus.in_ready), 32'd0);
      chk("writes_left", 32'(wq.size()), 32'd0);
      chk("reads_left", 32'(rq.size()), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit e;
    int a;
    int n;
    int r;
    total = 0;
    bad   = 0;
    for (int i = 0; i < M; i++) ref_mem[i] = 8'h00;
    reset = 1'b1;
    clr_mem = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    clr_mem = 1'b0;
    @(posedge clk); #1;

    fq = '{8'h01, 8'h00, 8'h05, 8'hAA, 8'hBB, 8'hCC};
    send_frame(fq, 0, 1'b0, 1'b1);
    fq = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_frame(fq, 0, 1'b0, 1'b1);
    fq = '{8'h01, 8'h01, 8'h3F, 8'h11, 8'h22};
    send_frame(fq, 0, 1'b0, 1'b1);
    fq = '{8'h02, 8'h01, 8'h3F, 8'h00, 8'h00};
    send_frame(fq, 1, 1'b0, 1'b1);
    fq = '{8'h01, 8'h01, 8'h40, 8'h55};
    send_frame(fq, 0, 1'b0, 1'b1);
    fq = '{8'h07, 8'h00, 8'h05, 8'h66, 8'h77};
    send_frame(fq, 0, 1'b0, 1'b1);
    fq = '{8'h01, 8'h00, 8'h10, 8'hC1, 8'hC2};
    send_frame(fq, 0, 1'b1, 1'b1);
    fq = '{8'h01, 8'h00};
    send_frame(fq, 0, 1'b0, 1'b1);
    fq = '{8'h02, 8'h00, 8'h05};
    send_frame(fq, 0, 1'b1, 1'b1);
    // aborted header followed directly by a new frame_start
    fq = '{8'h01, 8'h00};
    send_frame(fq, 0, 1'b0, 1'b0);
    fq = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h00};
    send_frame(fq, 0, 1'b0, 1'b1);

    // reset while a write burst is in flight
    fq = '{8'h01, 8'h00, 8'h05, 8'hA1, 8'hB2};
    model_frame(fq, e);
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    for (int i = 0; i < fq.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = fq[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #6;
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_writes_left", 32'(wq.size()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    fq = '{8'h01, 8'h00, 8'h00, 8'h5A};
    send_frame(fq, 0, 1'b0, 1'b1);
    fq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fq, 0, 1'b0, 1'b1);

    for (int f = 0; f < 40; f++) begin
      fq.delete();
      r = $urandom_range(9, 0);
      if (r < 5) fq.push_back(8'h01);
      else if (r < 9) fq.push_back(8'h02);
      else fq.push_back(8'(3 + $urandom_range(250, 0)));
      r = $urandom_range(9, 0);
      if (r == 0) a = $urandom_range(511, M);
      else if (r < 3) a = $urandom_range(M - 1, M - 5);
      else a = $urandom_range(M - 1, 0);
      fq.push_back({7'($urandom_range(127, 0)), 1'(a >> 8)});
      fq.push_back(8'(a));
      n = $urandom_range(6, 0);
      for (int k = 0; k < n; k++) fq.push_back(8'($urandom_range(255, 0)));
      if ($urandom_range(7, 0) == 0) begin
        while (fq.size() > 1 + $urandom_range(1, 0)) void'(fq.pop_back());
      end
      send_frame(fq, $urandom_range(2, 0), 1'($urandom_range(1, 0)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
